// File: rtl/bus_master_port_pkg.sv
// Shared types and default widths for the req/ack pin-bus master port.
package bus_master_port_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DW         = 8;
  localparam int unsigned CYCLE_W        = 16;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/bus_master_port_tmo.sv
// Wait counter for an outstanding bus request; flags expiry after TIMEOUT_CYCLES cycles in REQ.
module bus_master_port_tmo #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Expiry is seen on the edge that would complete the TIMEOUT_CYCLES-th cycle of req.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Single-outstanding master for the req/ack pin bus with a one-cycle response pulse.
// Optional request timeout enabled by defining BUS_TIMEOUT_EN.
module bus_master_port
  import bus_master_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DW-1:0]         cmd_wdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DW-1:0]         wr_data,
  input  logic [DW-1:0]         rd_data,
  output logic                  rw,
  output logic                  req,
  input  logic                  ack,
  input  logic                  err,
  output logic                  rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [CYCLE_W-1:0]    cycle_count
);

  state_e                state_q;
  logic                  req_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [DW-1:0]         wr_data_q;
  logic                  rsp_valid_q;
  logic [DW-1:0]         rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic [CYCLE_W-1:0]    cycle_count_q;

  logic                  tmo_c;
  logic                  done_c;

`ifdef BUS_TIMEOUT_EN
  bus_master_port_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == IDLE),
    .en_i      (state_q == REQ),
    .expired_o (tmo_c)
  );
`else
  assign tmo_c = 1'b0;
`endif

  assign done_c    = ack || err || tmo_c;
  assign cmd_ready = (state_q == IDLE);

  // Transfer FSM with registered bus pins and response fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      rw_q          <= RW_READ;
      address_q     <= '0;
      wr_data_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_q + CYCLE_W'(1);
      rsp_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q   <= REQ;
            req_q     <= 1'b1;
            rw_q      <= cmd_rw ? RW_WRITE : RW_READ;
            address_q <= cmd_addr;
            wr_data_q <= cmd_wdata;
          end
        end
        REQ: begin
          if (done_c) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            rsp_valid_q   <= 1'b1;
            // err beats ack; a slave reply on the expiry edge beats the timeout.
            rsp_err_q     <= err || !ack;
            rsp_timeout_q <= tmo_c && !ack && !err;
            rsp_rdata_q   <= (ack && !err && rw_q == RW_READ) ? rd_data : '0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req         = req_q;
  assign rw          = rw_q;
  assign address     = address_q;
  assign wr_data     = wr_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port; timeout steps are built only with BUS_TIMEOUT_EN.
module tb_bus_master_port;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rw;
  logic          req;
  logic          ack;
  logic          err;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [15:0]   cycle_count;

  int n_assert = 0;
  int n_fail   = 0;

  bus_master_port #(
    .ADDR_WIDTH     (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .address     (address),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rw          (rw),
    .req         (req),
    .ack         (ack),
    .err         (err),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n posedges; inputs are driven and outputs sampled at the following negedge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_rw    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rd_data = '0; ack = 1'b0; err = 1'b0;
    step(2);
    chk("reset_req", 32'(req), 32'h0);
    chk("reset_cycle_count", 32'(cycle_count), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b1;
    step(10);
    chk("idle10_cycle_count", 32'(cycle_count), 32'd10);
    chk("idle10_req", 32'(req), 32'h0);
    chk("idle10_cmd_ready", 32'(cmd_ready), 32'h1);

    // Stray ack/err while idle must be ignored.
    ack = 1'b1; err = 1'b1;
    step(1);
    ack = 1'b0; err = 1'b0;
    chk("idle_ack_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("idle_ack_req", 32'(req), 32'h0);

    // Write 0x1234 <= 0xA5, ack after three cycles of req.
    issue(1'b1, 16'h1234, 8'hA5);
    chk("wr_address", 32'(address), 32'h1234);
    chk("wr_wdata", 32'(wr_data), 32'hA5);
    chk("wr_rw", 32'(rw), 32'h1);
    chk("wr_cmd_ready_busy", 32'(cmd_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_req_cycle%0d", i), 32'(req), 32'h1);
      if (i == 3) ack = 1'b1;
      step(1);
    end
    ack = 1'b0;
    chk("wr_req_drop", 32'(req), 32'h0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    chk("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("wr_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("wr_cmd_ready_back", 32'(cmd_ready), 32'h1);
    step(1);
    chk("wr_rsp_valid_pulse", 32'(rsp_valid), 32'h0);

    // Read 0x00FF with 0x3C, with a write already queued behind it.
    issue(1'b0, 16'h00FF, 8'h00);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'h0042; cmd_wdata = 8'h5A;
    chk("rd_address", 32'(address), 32'h00FF);
    chk("rd_rw", 32'(rw), 32'h0);
    ack = 1'b1; rd_data = 8'h3C;
    step(1);
    ack = 1'b0; rd_data = 8'h77;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h3C);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);
    chk("rd_req_gap", 32'(req), 32'h0);
    step(1);
    cmd_valid = 1'b0;
    chk("q_req_rise", 32'(req), 32'h1);
    chk("q_address", 32'(address), 32'h0042);
    chk("q_wdata", 32'(wr_data), 32'h5A);
    chk("q_rsp_valid_low", 32'(rsp_valid), 32'h0);
    chk("q_rsp_rdata_hold", 32'(rsp_rdata), 32'h3C);

    // ack and err together: err wins.
    ack = 1'b1; err = 1'b1;
    step(1);
    ack = 1'b0; err = 1'b0;
    chk("both_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("both_rsp_err", 32'(rsp_err), 32'h1);
    chk("both_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("both_rsp_timeout", 32'(rsp_timeout), 32'h0);

    // Read ending in err discards rd_data.
    step(1);
    issue(1'b0, 16'h0010, 8'h00);
    err = 1'b1; rd_data = 8'hEE;
    step(1);
    err = 1'b0;
    chk("rderr_rsp_err", 32'(rsp_err), 32'h1);
    chk("rderr_rsp_rdata", 32'(rsp_rdata), 32'h0);
    step(1);

`ifdef BUS_TIMEOUT_EN
    // Silent slave: req held exactly TMO cycles, then timeout response.
    issue(1'b0, 16'h0100, 8'h00);
    n = 0;
    while (req && n < 20) begin
      n++;
      step(1);
    end
    chk("tmo_req_cycles", 32'(n), 32'(TMO));
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("tmo_rsp_err", 32'(rsp_err), 32'h1);
    chk("tmo_rsp_timeout", 32'(rsp_timeout), 32'h1);
    step(1);
    // ack on the expiry edge beats the timeout.
    issue(1'b0, 16'h0101, 8'h00);
    step(TMO - 1);
    ack = 1'b1; rd_data = 8'h99;
    step(1);
    ack = 1'b0;
    chk("tmo_ack_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("tmo_ack_rsp_err", 32'(rsp_err), 32'h0);
    chk("tmo_ack_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("tmo_ack_rsp_rdata", 32'(rsp_rdata), 32'h99);
    step(1);
`else
    // Without the timeout, req waits for the slave indefinitely.
    issue(1'b0, 16'h0100, 8'h00);
    n = 0;
    while (req && n < 20) begin
      n++;
      step(1);
    end
    chk("notmo_req_held", 32'(n), 32'd20);
    ack = 1'b1; rd_data = 8'h11;
    step(1);
    ack = 1'b0;
    chk("notmo_rsp_rdata", 32'(rsp_rdata), 32'h11);
    chk("notmo_rsp_timeout", 32'(rsp_timeout), 32'h0);
    step(1);
`endif

    // Reset during REQ drops req at once and yields no response.
    issue(1'b1, 16'h0ABC, 8'hC3);
    chk("rstmid_req_before", 32'(req), 32'h1);
    rst = 1'b0;
    #1;
    chk("rstmid_req_async", 32'(req), 32'h0);
    chk("rstmid_cycle_count", 32'(cycle_count), 32'h0);
    step(1);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b1;
    step(1);
    chk("rstmid_cycle_count_restart", 32'(cycle_count), 32'h1);
    chk("rstmid_rsp_valid_after", 32'(rsp_valid), 32'h0);
    issue(1'b0, 16'h0DEF, 8'h00);
    chk("post_rst_address", 32'(address), 32'h0DEF);
    ack = 1'b1; rd_data = 8'h81;
    step(1);
    ack = 1'b0;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_rsp_rdata", 32'(rsp_rdata), 32'h81);
    chk("post_rst_cycle_count", 32'(cycle_count), 32'h3);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
